// File: rtl/pkt_bufid_manager.sv
// Free packet-buffer ID manager: owns the circular free list, fills it after
// reset, offers one ID at a time over valid/ack and takes released IDs back.
module pkt_bufid_manager #(
  parameter int BUF_NUM = 512
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  output logic       o_pkt_bufid_wr,
  output logic [8:0] ov_pkt_bufid,
  input  logic       i_pkt_bufid_ack,
  input  logic       i_bufid_release_wr,
  input  logic [8:0] iv_bufid_release,
  output logic [8:0] ov_free_bufid_fifo_rdusedw,
  output logic       o_init_done,
  output logic       o_release_err_pulse,
  output logic [1:0] ov_bufid_manage_state
);

  localparam int AW = $clog2(BUF_NUM);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BUF_NUM - 1);
  localparam logic [9:0] BUF_NUM_W = 10'(BUF_NUM);

  // INIT fills list | IDLE offer empty | FETCH RAM data valid | OFFER bufid presented
  typedef enum logic [1:0] {
    INIT_S  = 2'b00,
    IDLE_S  = 2'b01,
    FETCH_S = 2'b10,
    OFFER_S = 2'b11
  } state_t;

  state_t r_state, w_state_nxt;

  logic [8:0]    r_ram [0:BUF_NUM-1];
  logic [8:0]    r_ram_q;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [9:0]    r_cnt;
  logic [8:0]    r_bufid;
  logic [8:0]    r_rdusedw;
  logic          r_init_done;
  logic          r_err;

  logic          w_cnt_nz;
  logic          w_offered;
  logic          w_rel_bad;
  logic          w_rel_ok;
  logic          w_init_wr;
  logic          w_rd_en;
  logic          w_load;
  logic          w_wr_en;
  logic [8:0]    w_wr_data;

  function automatic logic [AW-1:0] f_ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  assign w_cnt_nz  = (r_cnt != 10'd0);
  assign w_offered = (r_state == FETCH_S) || (r_state == OFFER_S);
  // A full list means the returned ID is already free: treat it as a double release.
  assign w_rel_bad = (r_state == INIT_S)
                  || ({1'b0, iv_bufid_release} >= BUF_NUM_W)
                  || ((r_cnt + {9'd0, w_offered}) == BUF_NUM_W);
  assign w_rel_ok  = i_bufid_release_wr && !w_rel_bad;
  assign w_wr_en   = w_init_wr || w_rel_ok;
  assign w_wr_data = w_init_wr ? 9'(r_wr_ptr) : iv_bufid_release;

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    w_rd_en     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      INIT_S: begin
        w_init_wr = 1'b1;
        if (r_wr_ptr == LAST_ADDR) w_state_nxt = IDLE_S;
      end
      IDLE_S: begin
        if (w_cnt_nz) begin
          w_rd_en     = 1'b1;
          w_state_nxt = FETCH_S;
        end
      end
      FETCH_S: begin
        w_load      = 1'b1;
        w_state_nxt = OFFER_S;
      end
      OFFER_S: begin
        if (i_pkt_bufid_ack) begin
          if (w_cnt_nz) begin
            w_rd_en     = 1'b1;
            w_state_nxt = FETCH_S;
          end else begin
            w_state_nxt = IDLE_S;
          end
        end
      end
      default: w_state_nxt = INIT_S;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (w_wr_en) r_ram[r_wr_ptr] <= w_wr_data;
    if (w_rd_en) r_ram_q <= r_ram[r_rd_ptr];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= INIT_S;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= 10'd0;
      r_bufid     <= 9'd0;
      r_rdusedw   <= 9'd0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_rd_en) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_cnt <= r_cnt + 10'd1;
        2'b01:   r_cnt <= r_cnt - 10'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_load) r_bufid <= r_ram_q;
      r_rdusedw <= (r_cnt > 10'd511) ? 9'd511 : r_cnt[8:0];
      if ((r_state == INIT_S) && (w_state_nxt == IDLE_S)) r_init_done <= 1'b1;
      r_err <= i_bufid_release_wr && w_rel_bad;
    end
  end

  assign o_pkt_bufid_wr             = (r_state == OFFER_S);
  assign ov_pkt_bufid               = r_bufid;
  assign ov_free_bufid_fifo_rdusedw = r_rdusedw;
  assign o_init_done                = r_init_done;
  assign o_release_err_pulse        = r_err;
  assign ov_bufid_manage_state      = r_state;

endmodule

// File: tb/tb_pkt_bufid_manager.sv
// Bench for pkt_bufid_manager (BUF_NUM=16): directed timing checks plus random
// ack/release traffic compared each cycle against a queue-based free-list model.
module tb_pkt_bufid_manager;

  localparam int N = 16;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       o_pkt_bufid_wr;
  logic [8:0] ov_pkt_bufid;
  logic       i_pkt_bufid_ack = 1'b0;
  logic       i_bufid_release_wr = 1'b0;
  logic [8:0] iv_bufid_release = 9'd0;
  logic [8:0] ov_free_bufid_fifo_rdusedw;
  logic       o_init_done;
  logic       o_release_err_pulse;
  logic [1:0] ov_bufid_manage_state;

  pkt_bufid_manager #(.BUF_NUM(N)) dut (
    .clk_sys                    (clk_sys),
    .reset_n                    (reset_n),
    .o_pkt_bufid_wr             (o_pkt_bufid_wr),
    .ov_pkt_bufid               (ov_pkt_bufid),
    .i_pkt_bufid_ack            (i_pkt_bufid_ack),
    .i_bufid_release_wr         (i_bufid_release_wr),
    .iv_bufid_release           (iv_bufid_release),
    .ov_free_bufid_fifo_rdusedw (ov_free_bufid_fifo_rdusedw),
    .o_init_done                (o_init_done),
    .o_release_err_pulse        (o_release_err_pulse),
    .ov_bufid_manage_state      (ov_bufid_manage_state)
  );

  always #5 clk_sys = ~clk_sys;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int got[$];
  int got_cyc[$];

  // Reference: free IDs as a queue, plus one slot holding the ID taken out of it.
  int q[$];
  int outst[$];
  bit m_busy;
  int m_age;
  int m_slot;
  int m_shown;
  int m_init_k;
  bit m_err;
  int m_used;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mdl_reset();
    q.delete();
    outst.delete();
    m_busy = 0; m_age = 0; m_slot = 0; m_shown = 0;
    m_init_k = 0; m_err = 0; m_used = 0;
  endtask

  task automatic mdl_edge(input bit ack, input bit rw, input int rid);
    bit done, vis, take, rel_ok;
    int pre;
    done   = (m_init_k == N);
    vis    = m_busy && (m_age >= 1);
    pre    = q.size();
    rel_ok = rw && done && (rid < N) && ((pre + (m_busy ? 1 : 0)) != N);
    m_err  = rw && !rel_ok;
    if (vis && ack) begin
      outst.push_back(m_slot);
      m_busy = 0;
    end
    if (m_busy && m_age == 0) begin
      m_age   = 1;
      m_shown = m_slot;
    end
    take = done && (pre > 0) && !m_busy;
    if (take) begin
      m_slot = q.pop_front();
      m_busy = 1;
      m_age  = 0;
    end
    if (rel_ok) begin
      q.push_back(rid);
      for (int i = 0; i < outst.size(); i++)
        if (outst[i] == rid) begin
          outst.delete(i);
          break;
        end
    end
    if (!done) begin
      q.push_back(m_init_k);
      m_init_k++;
    end
    m_used = (pre > 511) ? 511 : pre;
  endtask

  function automatic int exp_state();
    if (m_init_k != N) return 0;
    if (m_busy && m_age >= 1) return 3;
    if (m_busy) return 2;
    return 1;
  endfunction

  task automatic step(input bit ack, input bit rw, input int rid);
    i_pkt_bufid_ack    = ack;
    i_bufid_release_wr = rw;
    iv_bufid_release   = 9'(rid);
    if (ack && o_pkt_bufid_wr) begin
      got.push_back(int'(ov_pkt_bufid));
      got_cyc.push_back(cyc);
    end
    @(posedge clk_sys);
    mdl_edge(ack, rw, rid);
    #1;
    chk("wr",      int'(o_pkt_bufid_wr), (m_busy && m_age >= 1) ? 1 : 0);
    chk("bufid",   int'(ov_pkt_bufid), m_shown);
    chk("rdusedw", int'(ov_free_bufid_fifo_rdusedw), m_used);
    chk("done",    int'(o_init_done), (m_init_k == N) ? 1 : 0);
    chk("err",     int'(o_release_err_pulse), int'(m_err));
    chk("state",   int'(ov_bufid_manage_state), exp_state());
    cyc++;
  endtask

  task automatic do_reset();
    reset_n            = 1'b0;
    i_pkt_bufid_ack    = 1'b0;
    i_bufid_release_wr = 1'b0;
    iv_bufid_release   = 9'd0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    mdl_reset();
    cyc = 0;
    got.delete();
    got_cyc.delete();
  endtask

  // Edges 0..17 after reset; optional release attempt while still initializing.
  task automatic run_init(input bit rel_in_init);
    for (int e = 0; e < 18; e++) begin
      if (rel_in_init && e == 3) step(0, 1, 7);
      else step(0, 0, 0);
      if (rel_in_init && e == 3) chk("init_rel_err", int'(o_release_err_pulse), 1);
      if (e == 14) chk("init_done_early", int'(o_init_done), 0);
      if (e == 15) chk("init_done_c16", int'(o_init_done), 1);
      if (e == 17) begin
        chk("first_wr_c18", int'(o_pkt_bufid_wr), 1);
        chk("first_id_c18", int'(ov_pkt_bufid), 0);
        chk("first_used_c18", int'(ov_free_bufid_fifo_rdusedw), 15);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp5[5];
    int r, id;
    bit rw;

    do_reset();
    run_init(1'b1);

    step(0, 1, 2);
    chk("full_rel_err", int'(o_release_err_pulse), 1);
    chk("full_rel_used", int'(ov_free_bufid_fifo_rdusedw), 15);
    step(0, 1, 20);
    chk("range_rel_err", int'(o_release_err_pulse), 1);

    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 60 && got.size() < N; i++) step(1, 0, 0);
    chk("drain_cnt", got.size(), N);
    for (int k = 0; k < got.size(); k++) begin
      chk("drain_id", got[k], k);
      if (k > 0) chk("drain_gap", got_cyc[k] - got_cyc[k-1], 2);
    end
    repeat (3) step(0, 0, 0);
    chk("empty_wr", int'(o_pkt_bufid_wr), 0);
    chk("empty_used", int'(ov_free_bufid_fifo_rdusedw), 0);
    chk("empty_state", int'(ov_bufid_manage_state), 1);

    step(0, 1, 5);
    step(0, 0, 0);
    chk("rel5_early_wr", int'(o_pkt_bufid_wr), 0);
    step(0, 0, 0);
    chk("rel5_wr", int'(o_pkt_bufid_wr), 1);
    chk("rel5_id", int'(ov_pkt_bufid), 5);
    chk("rel5_used", int'(ov_free_bufid_fifo_rdusedw), 0);

    for (int k = 10; k < 14; k++) step(0, 1, k);
    step(1, 1, 3);
    step(0, 0, 0);
    chk("simul_used", int'(ov_free_bufid_fifo_rdusedw), 4);
    got.delete();
    got_cyc.delete();
    exp5 = '{10, 11, 12, 13, 3};
    for (int i = 0; i < 30 && got.size() < 5; i++) step(1, 0, 0);
    chk("simul_cnt", got.size(), 5);
    for (int k = 0; k < got.size() && k < 5; k++) chk("simul_order", got[k], exp5[k]);

    step(0, 1, 20);
    chk("range2_err", int'(o_release_err_pulse), 1);
    step(0, 0, 0);
    chk("err_one_cycle", int'(o_release_err_pulse), 0);

    for (int i = 0; i < 400; i++) begin
      rw = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 9);
      if (r < 6 && outst.size() > 0) id = outst[$urandom_range(0, outst.size() - 1)];
      else if (r < 8) id = $urandom_range(N, 511);
      else id = $urandom_range(0, N - 1);
      step(bit'($urandom_range(0, 1)), rw, id);
    end

    do_reset();
    run_init(1'b0);
    got.delete();
    for (int i = 0; i < 40 && got.size() < 7; i++) step(1, 0, 0);
    for (int i = 0; i < 5 && !o_pkt_bufid_wr; i++) step(0, 0, 0);
    chk("mid_handed", got.size(), 7);
    chk("mid_offer", int'(ov_bufid_manage_state), 3);
    reset_n = 1'b0;
    #1;
    chk("rst_wr", int'(o_pkt_bufid_wr), 0);
    chk("rst_id", int'(ov_pkt_bufid), 0);
    chk("rst_used", int'(ov_free_bufid_fifo_rdusedw), 0);
    chk("rst_done", int'(o_init_done), 0);
    chk("rst_err", int'(o_release_err_pulse), 0);
    chk("rst_state", int'(ov_bufid_manage_state), 0);
    do_reset();
    run_init(1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
